// File: rtl/mpsoc_ahb3_pkg.sv
// ---------------------------------------------------------------------------
// mpsoc_ahb3_pkg
// Shared definitions for the AHB3 memory subsystem.
//   - HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ)
//   - HSIZE encodings (BYTE/HWORD/WORD/DWORD)
//   - HRESP encodings (OKAY/ERROR)
//   - helpers: transfer-active decode, alignment check, byte-enable mask
// ---------------------------------------------------------------------------
package mpsoc_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // NONSEQ and SEQ carry a real transfer; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] htrans);
    logic active;
    active = 1'b0;
    case (htrans)
      HTRANS_IDLE:   active = 1'b0;
      HTRANS_BUSY:   active = 1'b0;
      HTRANS_NONSEQ: active = 1'b1;
      HTRANS_SEQ:    active = 1'b1;
    endcase
    return active;
  endfunction

  // True when the low address bits are not a multiple of 2^hsize.
  // Sizes above DWORD are rejected separately by the size check.
  function automatic logic is_misaligned(input logic [2:0] hsize,
                                         input logic [2:0] addr_lo);
    logic mis;
    case (hsize)
      HSIZE_BYTE:  mis = 1'b0;
      HSIZE_HWORD: mis = addr_lo[0];
      HSIZE_WORD:  mis = |addr_lo[1:0];
      default:     mis = |addr_lo[2:0];
    endcase
    return mis;
  endfunction

  // Contiguous 2^hsize-byte mask starting at byte lane 'lane'.
  // Callers keep only the low DBITS/8 bits.
  function automatic logic [7:0] gen_byte_enable(input logic [2:0] hsize,
                                                 input logic [2:0] lane);
    logic [7:0] base;
    case (hsize)
      HSIZE_BYTE:  base = 8'h01;
      HSIZE_HWORD: base = 8'h03;
      HSIZE_WORD:  base = 8'h0F;
      HSIZE_DWORD: base = 8'hFF;
      default:     base = 8'hFF;
    endcase
    return base << lane;
  endfunction

endpackage

// File: rtl/mpsoc_ahb3_ram_bridge.sv
// ---------------------------------------------------------------------------
// mpsoc_ahb3_ram_bridge
// AHB3-Lite slave front end for a one-read/one-write RAM with registered read.
// Legal transfers complete with zero wait states; illegal ones (oversize or
// misaligned) get a two-cycle ERROR response and never touch the RAM.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   HSEL..HREADY             AHB address/control/write-data inputs
//   HRDATA, HREADYOUT, HRESP AHB response outputs
//   mem_waddr_o, mem_din_o,
//   mem_we_o, mem_be_o       RAM write port (driven in the write data phase)
//   mem_raddr_o              RAM read address (combinational from HADDR)
//   mem_dout_i               RAM read data, one cycle after mem_raddr_o
// ---------------------------------------------------------------------------
module mpsoc_ahb3_ram_bridge
  import mpsoc_ahb3_pkg::*;
#(
  parameter int ABITS      = 10,
  parameter int DBITS      = 32,
  parameter int HADDR_SIZE = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [DBITS-1:0]      HWDATA,
  output logic [DBITS-1:0]      HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [ABITS-1:0]      mem_waddr_o,
  output logic [DBITS-1:0]      mem_din_o,
  output logic                  mem_we_o,
  output logic [DBITS/8-1:0]    mem_be_o,
  output logic [ABITS-1:0]      mem_raddr_o,
  input  logic [DBITS-1:0]      mem_dout_i
);

  localparam int BW = DBITS / 8;
  localparam int LB = $clog2(BW);

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } resp_state_e;

  resp_state_e state;

  logic             accept;
  logic             legal;
  logic             take_write;
  logic             take_read;
  logic             raw_hit;
  logic [ABITS-1:0] word_addr;
  logic [7:0]       be_full;
  logic [BW-1:0]    be;

  // Data-phase state
  logic             wr_pend;
  logic             rd_pend;
  logic [ABITS-1:0] wr_addr;
  logic [BW-1:0]    wr_be;

  // Read-after-write bypass
  logic             byp_hit;
  logic [DBITS-1:0] byp_data;
  logic [BW-1:0]    byp_be;

  // Address-phase decode
  always_comb begin
    accept     = HSEL & HREADY & trans_active(HTRANS);
    word_addr  = HADDR[ABITS+LB-1:LB];
    legal      = (HSIZE <= 3'(LB)) && !is_misaligned(HSIZE, HADDR[2:0]);
    be_full    = gen_byte_enable(HSIZE, 3'(HADDR[LB-1:0]));
    be         = be_full[BW-1:0];
    take_write = accept & legal & HWRITE;
    take_read  = accept & legal & ~HWRITE;
    // The write in its data phase lands in the RAM at this same edge, so the
    // RAM's read port would return the old word; catch it here.
    raw_hit    = take_read & wr_pend & (wr_addr == word_addr);
  end

  // Data-phase registers only advance when the bus is ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_pend  <= 1'b0;
      rd_pend  <= 1'b0;
      wr_addr  <= '0;
      wr_be    <= '0;
      byp_hit  <= 1'b0;
      byp_data <= '0;
      byp_be   <= '0;
    end else if (HREADY) begin
      wr_pend <= take_write;
      rd_pend <= take_read;
      byp_hit <= raw_hit;
      if (take_write) begin
        wr_addr <= word_addr;
        wr_be   <= be;
      end else begin
        wr_be   <= '0;
      end
      if (raw_hit) begin
        byp_data <= HWDATA;
        byp_be   <= wr_be;
      end
    end
  end

  // Response FSM with registered HREADYOUT/HRESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_OK;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_OK: begin
          if (accept && !legal) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        ST_ERR2: begin
          if (accept && !legal) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
          end else begin
            state     <= ST_OK;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
          end
        end
        default: begin
          state     <= ST_OK;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign mem_waddr_o = wr_addr;
  assign mem_din_o   = HWDATA;
  assign mem_we_o    = wr_pend;
  assign mem_be_o    = wr_be;
  assign mem_raddr_o = word_addr;

  // Per-lane merge of bypassed write data over the RAM output.
  always_comb begin
    HRDATA = '0;
    if (rd_pend) begin
      for (int i = 0; i < BW; i++) begin
        if (byp_hit && byp_be[i]) HRDATA[8*i +: 8] = byp_data[8*i +: 8];
        else                      HRDATA[8*i +: 8] = mem_dout_i[8*i +: 8];
      end
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HADDR, be_full};

endmodule

// File: tb/tb_mpsoc_ahb3_ram_bridge.sv
// ---------------------------------------------------------------------------
// tb_mpsoc_ahb3_ram_bridge
// Directed bench for the AHB3 RAM bridge with a behavioural read-first RAM.
// ---------------------------------------------------------------------------
module tb_mpsoc_ahb3_ram_bridge;
  import mpsoc_ahb3_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [9:0]  mem_waddr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [9:0]  mem_raddr;
  logic [31:0] mem_dout;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mpsoc_ahb3_ram_bridge #(.ABITS(10), .DBITS(32), .HADDR_SIZE(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .HSEL       (hsel),
    .HADDR      (haddr),
    .HWDATA     (hwdata),
    .HRDATA     (hrdata),
    .HWRITE     (hwrite),
    .HSIZE      (hsize),
    .HBURST     (hburst),
    .HPROT      (hprot),
    .HTRANS     (htrans),
    .HMASTLOCK  (hmastlock),
    .HREADY     (hready),
    .HREADYOUT  (hreadyout),
    .HRESP      (hresp),
    .mem_waddr_o(mem_waddr),
    .mem_din_o  (mem_din),
    .mem_we_o   (mem_we),
    .mem_be_o   (mem_be),
    .mem_raddr_o(mem_raddr),
    .mem_dout_i (mem_dout)
  );

  // Read-first RAM with registered output
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    mem_dout <= ram[mem_raddr];
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) ram[mem_waddr][8*b +: 8] <= mem_din[8*b +: 8];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic beat(input logic [1:0] tr, input logic wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata);
    hsel   = 1'b1;
    htrans = tr;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
    hwdata = wdata;
  endtask

  task automatic test_reset();
    hwdata = 32'hA5A5_A5A5;
    #1;
    tests_run++; if (hreadyout !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_hreadyout got %b want 1", hreadyout); end
    tests_run++; if (hresp !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hresp got %b want 0", hresp); end
    tests_run++; if (hrdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_hrdata got %h want 0", hrdata); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_we got %b want 0", mem_we); end
    tests_run++; if (mem_be !== 4'b0) begin tests_failed++; $display("[TB] FAIL reset_be got %b want 0", mem_be); end
    tests_run++; if (mem_waddr !== 10'h0) begin tests_failed++; $display("[TB] FAIL reset_waddr got %h want 0", mem_waddr); end
    tests_run++; if (mem_din !== 32'hA5A5_A5A5) begin tests_failed++; $display("[TB] FAIL reset_din got %h want a5a5a5a5", mem_din); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_byte_write();
    beat(HTRANS_NONSEQ, 1'b1, 32'h5, HSIZE_BYTE, 32'h0);
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0000_AB00);
    mid();
    tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL byte_we got %b want 1", mem_we); end
    tests_run++; if (mem_be !== 4'b0010) begin tests_failed++; $display("[TB] FAIL byte_be got %b want 0010", mem_be); end
    tests_run++; if (mem_waddr !== 10'h1) begin tests_failed++; $display("[TB] FAIL byte_waddr got %h want 1", mem_waddr); end
    step();
    beat(HTRANS_NONSEQ, 1'b0, 32'h4, HSIZE_WORD, 32'h0);
    mid();
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL byte_we_after got %b want 0", mem_we); end
    tests_run++; if (hrdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL byte_hrdata_idle got %h want 0", hrdata); end
    tests_run++; if (mem_raddr !== 10'h1) begin tests_failed++; $display("[TB] FAIL byte_raddr got %h want 1", mem_raddr); end
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    mid();
    tests_run++; if (hrdata !== 32'h0000_AB00) begin tests_failed++; $display("[TB] FAIL byte_readback got %h want 0000ab00", hrdata); end
    step();
  endtask

  task automatic test_raw_bypass();
    beat(HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'h0);
    step();
    beat(HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'hDEAD_BEEF);
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    mid();
    tests_run++; if (hrdata !== 32'hDEAD_BEEF) begin tests_failed++; $display("[TB] FAIL bypass_word got %h want deadbeef", hrdata); end
    tests_run++; if (hreadyout !== 1'b1) begin tests_failed++; $display("[TB] FAIL bypass_ready got %b want 1", hreadyout); end
    step();
  endtask

  task automatic test_merge();
    beat(HTRANS_NONSEQ, 1'b1, 32'h42, HSIZE_HWORD, 32'h0);
    step();
    beat(HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'h1234_5678);
    mid();
    tests_run++; if (mem_be !== 4'b1100) begin tests_failed++; $display("[TB] FAIL merge_be got %b want 1100", mem_be); end
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    mid();
    tests_run++; if (hrdata !== 32'h1234_BEEF) begin tests_failed++; $display("[TB] FAIL merge_hrdata got %h want 1234beef", hrdata); end
    step();
  endtask

  task automatic test_error_response();
    beat(HTRANS_NONSEQ, 1'b0, 32'h41, HSIZE_WORD, 32'h0);
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    hready = 1'b0;
    mid();
    tests_run++; if (hreadyout !== 1'b0) begin tests_failed++; $display("[TB] FAIL err1_ready got %b want 0", hreadyout); end
    tests_run++; if (hresp !== 1'b1) begin tests_failed++; $display("[TB] FAIL err1_resp got %b want 1", hresp); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL err1_we got %b want 0", mem_we); end
    tests_run++; if (hrdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL err1_hrdata got %h want 0", hrdata); end
    step();
    hready = 1'b1;
    beat(HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'h0);
    mid();
    tests_run++; if (hreadyout !== 1'b1) begin tests_failed++; $display("[TB] FAIL err2_ready got %b want 1", hreadyout); end
    tests_run++; if (hresp !== 1'b1) begin tests_failed++; $display("[TB] FAIL err2_resp got %b want 1", hresp); end
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    mid();
    tests_run++; if (hresp !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_recover_resp got %b want 0", hresp); end
    tests_run++; if (hrdata !== 32'h1234_BEEF) begin tests_failed++; $display("[TB] FAIL err_recover_data got %h want 1234beef", hrdata); end
    step();
    // Oversize write, then a misaligned write presented in ERR2
    beat(HTRANS_NONSEQ, 1'b1, 32'h80, HSIZE_DWORD, 32'h0);
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'hFFFF_FFFF);
    hready = 1'b0;
    mid();
    tests_run++; if (hreadyout !== 1'b0) begin tests_failed++; $display("[TB] FAIL size_err_ready got %b want 0", hreadyout); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL size_err_we got %b want 0", mem_we); end
    step();
    hready = 1'b1;
    beat(HTRANS_NONSEQ, 1'b1, 32'h43, HSIZE_HWORD, 32'hFFFF_FFFF);
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'hFFFF_FFFF);
    hready = 1'b0;
    mid();
    tests_run++; if (hreadyout !== 1'b0) begin tests_failed++; $display("[TB] FAIL rerr_ready got %b want 0", hreadyout); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL rerr_we got %b want 0", mem_we); end
    step();
    hready = 1'b1;
    step();
    mid();
    tests_run++; if (hresp !== 1'b0 || hreadyout !== 1'b1) begin tests_failed++; $display("[TB] FAIL rerr_recover got resp=%b ready=%b want 0/1", hresp, hreadyout); end
    step();
  endtask

  task automatic test_burst();
    logic [1:0]  wtr   [7];
    logic [31:0] waddr [7];
    logic [31:0] wdat  [7];
    logic        ewe   [7];
    logic [9:0]  ewa   [7];
    logic [1:0]  rtr   [6];
    logic [31:0] raddr [6];
    logic [31:0] erd   [6];
    wtr   = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE};
    waddr = '{32'h100, 32'h104, 32'h108, 32'h108, 32'h10C, 32'h0, 32'h0};
    wdat  = '{32'h0, 32'hC0DE_0000, 32'hC0DE_0001, 32'h0, 32'hC0DE_0002, 32'hC0DE_0003, 32'h0};
    ewe   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    ewa   = '{10'h0, 10'h40, 10'h41, 10'h0, 10'h42, 10'h43, 10'h0};
    for (int i = 0; i < 7; i++) begin
      beat(wtr[i], wtr[i][1], waddr[i], HSIZE_WORD, wdat[i]);
      mid();
      tests_run++; if (mem_we !== ewe[i]) begin tests_failed++; $display("[TB] FAIL burst_we[%0d] got %b want %b", i, mem_we, ewe[i]); end
      if (ewe[i]) begin
        tests_run++; if (mem_waddr !== ewa[i]) begin tests_failed++; $display("[TB] FAIL burst_waddr[%0d] got %h want %h", i, mem_waddr, ewa[i]); end
      end
      tests_run++; if (hreadyout !== 1'b1) begin tests_failed++; $display("[TB] FAIL burst_wready[%0d] got %b want 1", i, hreadyout); end
      step();
    end
    rtr   = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE};
    raddr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h0, 32'h0};
    erd   = '{32'h0, 32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'h0};
    for (int i = 0; i < 6; i++) begin
      beat(rtr[i], 1'b0, raddr[i], HSIZE_WORD, 32'h0);
      mid();
      tests_run++; if (hrdata !== erd[i]) begin tests_failed++; $display("[TB] FAIL burst_rdata[%0d] got %h want %h", i, hrdata, erd[i]); end
      tests_run++; if (hreadyout !== 1'b1) begin tests_failed++; $display("[TB] FAIL burst_rready[%0d] got %b want 1", i, hreadyout); end
      step();
    end
  endtask

  task automatic test_hready_hold();
    beat(HTRANS_NONSEQ, 1'b1, 32'h204, HSIZE_WORD, 32'h0);
    step();
    beat(HTRANS_NONSEQ, 1'b1, 32'h208, HSIZE_WORD, 32'h0BAD_F00D);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        hready = 1'b1;
        beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0BAD_F00D);
      end
      mid();
      tests_run++; if (mem_we !== 1'b1 || mem_waddr !== 10'h81) begin tests_failed++; $display("[TB] FAIL hold[%0d] got we=%b waddr=%h want 1/081", i, mem_we, mem_waddr); end
      step();
    end
    mid();
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_release_we got %b want 0", mem_we); end
    beat(HTRANS_NONSEQ, 1'b0, 32'h204, HSIZE_WORD, 32'h0);
    step();
    beat(HTRANS_NONSEQ, 1'b0, 32'h208, HSIZE_WORD, 32'h0);
    mid();
    tests_run++; if (hrdata !== 32'h0BAD_F00D) begin tests_failed++; $display("[TB] FAIL hold_word204 got %h want 0badf00d", hrdata); end
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    mid();
    tests_run++; if (hrdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL hold_word208 got %h want 0", hrdata); end
    step();
  endtask

  task automatic test_reset_mid_write();
    beat(HTRANS_NONSEQ, 1'b1, 32'h300, HSIZE_WORD, 32'h0);
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h55AA_55AA);
    tests_run++; if (mem_we !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_pre_we got %b want 1", mem_we); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_we got %b want 0", mem_we); end
    tests_run++; if (mem_be !== 4'b0 || mem_waddr !== 10'h0) begin tests_failed++; $display("[TB] FAIL rstmid_port got be=%b waddr=%h want 0/0", mem_be, mem_waddr); end
    tests_run++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL rstmid_resp got ready=%b resp=%b data=%h want 1/0/0", hreadyout, hresp, hrdata); end
    step();
    rst_n = 1'b1;
    step();
    beat(HTRANS_NONSEQ, 1'b0, 32'h300, HSIZE_WORD, 32'h0);
    step();
    beat(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
    mid();
    tests_run++; if (hrdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL rstmid_word got %h want 0", hrdata); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    rst_n     = 1'b0;
    hsel      = 1'b0;
    haddr     = 32'h0;
    hwdata    = 32'h0;
    hwrite    = 1'b0;
    hsize     = HSIZE_WORD;
    hburst    = 3'b000;
    hprot     = 4'b0011;
    htrans    = HTRANS_IDLE;
    hmastlock = 1'b0;
    hready    = 1'b1;
    #12;
    test_reset();
    test_byte_write();
    test_raw_bypass();
    test_merge();
    test_error_response();
    test_burst();
    test_hready_hold();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the test sequence ended");
    $fatal(1, "[TB] watchdog");
  end

endmodule
